// File: rtl/shift_reg_piso_tx.sv
// Parallel-in / serial-out transmitter. It sends each word MSB first and holds one more
// word in reserve, so back-to-back words go out with no gap in the serial stream.
module shift_reg_piso_tx #(
    parameter int SHLEN = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             load_vld_i,
    input  logic [SHLEN-1:0] din_i,
    output logic             load_rdy_o,
    output logic             sout_o,
    output logic             sen_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = (SHLEN > 2) ? $clog2(SHLEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SHLEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [SHLEN-1:0] shreg_q;
    logic [SHLEN-1:0] hold_q;
    logic [CW-1:0]    bitcnt_q;
    logic             hold_full_q;
    logic             done_q;
    logic             accept;
    logic             last_bit;

    assign load_rdy_o = ~hold_full_q;
    assign accept     = load_vld_i & load_rdy_o;
    assign last_bit   = en_i & (bitcnt_q == '0);

    // SEN is combinational, so a downstream receiver captures SOUT on the same edge.
    assign busy_o = (state_q == SHIFT);
    assign sen_o  = en_i & busy_o;
    assign sout_o = busy_o & shreg_q[SHLEN-1];
    assign done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            bitcnt_q    <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q  <= din_i;
                        bitcnt_q <= CNT_MAX;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        done_q <= 1'b1;
                        // A held word wins over a new load; LOAD_RDY is low then anyway.
                        if (hold_full_q) begin
                            shreg_q     <= hold_q;
                            hold_full_q <= 1'b0;
                            bitcnt_q    <= CNT_MAX;
                        end else if (accept) begin
                            shreg_q  <= din_i;
                            bitcnt_q <= CNT_MAX;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (en_i) begin
                            shreg_q  <= {shreg_q[SHLEN-2:0], 1'b0};
                            bitcnt_q <= bitcnt_q - CNT_ONE;
                        end
                        if (accept) begin
                            hold_q      <= din_i;
                            hold_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Bench for shift_reg_piso_tx: directed scenarios plus random traffic, checked each cycle
// against a word-queue transaction model and an emulated SIPO receiver.
module tb_shift_reg_piso_tx;
    localparam int SHLEN = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             vld = 1'b0;
    logic [SHLEN-1:0] din = '0;
    logic             rdy, sout, sen, busy, done;

    int total = 0;
    int bad = 0;

    // Model: queue of words owed to the line (front = being sent, second = held).
    logic [SHLEN-1:0] wq[$];
    int               bits_left = 0;
    logic             m_done = 1'b0;
    logic [SHLEN-1:0] last_word = '0;
    logic [SHLEN-1:0] sipo = '0;
    logic             s_sen, s_sout;

    shift_reg_piso_tx #(.SHLEN(SHLEN)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_vld_i(vld), .din_i(din),
        .load_rdy_o(rdy), .sout_o(sout), .sen_o(sen), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string where);
        logic [SHLEN-1:0] cur;
        logic             m_busy, m_sout;
        m_busy = (wq.size() > 0);
        cur    = m_busy ? wq[0] : '0;
        m_sout = m_busy ? cur[bits_left-1] : 1'b0;
        chk({where, ".load_rdy"}, 32'(rdy), 32'(wq.size() < 2));
        chk({where, ".busy"}, 32'(busy), 32'(m_busy));
        chk({where, ".sout"}, 32'(sout), 32'(m_sout));
        chk({where, ".sen"}, 32'(sen), 32'(en & m_busy));
        chk({where, ".done"}, 32'(done), 32'(m_done));
        if (m_done) chk({where, ".sipo"}, 32'(sipo), 32'(last_word));
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [SHLEN-1:0] d);
        logic acc;
        if (!rst_n) begin
            wq.delete();
            m_done = 1'b0;
            return;
        end
        acc    = v && (wq.size() < 2);
        m_done = 1'b0;
        if (wq.size() > 0 && e) begin
            bits_left--;
            if (bits_left == 0) begin
                m_done    = 1'b1;
                last_word = wq.pop_front();
                bits_left = SHLEN;
            end
        end
        if (acc) begin
            if (wq.size() == 0) bits_left = SHLEN;
            wq.push_back(d);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic cyc(input string where, input logic e, input logic v,
                       input logic [SHLEN-1:0] d);
        en = e; vld = v; din = d;
        @(negedge clk);
        check_outs(where);
        s_sen = sen; s_sout = sout;
        @(posedge clk);
        model_edge(e, v, d);
        if (s_sen) sipo = {sipo[SHLEN-2:0], s_sout};
        #1;
    endtask

    task automatic async_rst(input string where);
        #2;
        rst_n = 1'b0;
        #1;
        wq.delete();
        m_done = 1'b0;
        check_outs(where);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held with random inputs
        for (int i = 0; i < 4; i++)
            cyc("reset", 1'($urandom), 1'($urandom), SHLEN'($urandom));
        rst_n = 1'b1;
        cyc("idle", 1'b1, 1'b0, '0);

        // Single word, EN always high
        cyc("single", 1'b1, 1'b1, 6'b101101);
        for (int i = 0; i < 8; i++) cyc("single", 1'b1, 1'b0, SHLEN'($urandom));
        chk("single.sipo_end", 32'(sipo), 32'h2D);

        // Slow tick: EN every 4th cycle
        cyc("slow", 1'b0, 1'b1, 6'h2A);
        for (int i = 0; i < 28; i++) cyc("slow", (i % 4) == 3, 1'b0, SHLEN'($urandom));
        chk("slow.sipo_end", 32'(sipo), 32'h2A);

        // Back-to-back: second word two cycles after the first
        cyc("b2b", 1'b1, 1'b1, 6'h2A);
        cyc("b2b", 1'b1, 1'b0, '0);
        cyc("b2b", 1'b1, 1'b1, 6'h15);
        for (int i = 0; i < 4; i++) cyc("b2b", 1'b1, 1'b1, SHLEN'($urandom));
        for (int i = 0; i < 9; i++) cyc("b2b", 1'b1, 1'b0, '0);
        chk("b2b.sipo_end", 32'(sipo), 32'h15);

        // Same-edge load on the last bit of 6'h01 with HOLD empty
        cyc("same", 1'b1, 1'b1, 6'h01);
        for (int i = 0; i < 5; i++) cyc("same", 1'b1, 1'b0, '0);
        cyc("same", 1'b1, 1'b1, 6'h3F);
        chk("same.sout_msb", 32'(sout), 32'h1);
        for (int i = 0; i < 8; i++) cyc("same", 1'b1, 1'b0, '0);
        chk("same.sipo_end", 32'(sipo), 32'h3F);

        // Reset mid-word with a word held
        cyc("midrst", 1'b0, 1'b1, 6'h2A);
        cyc("midrst", 1'b1, 1'b1, 6'h15);
        cyc("midrst", 1'b1, 1'b0, '0);
        cyc("midrst", 1'b1, 1'b0, '0);
        async_rst("midrst.async");
        cyc("midrst.hold", 1'b1, 1'b1, 6'h33);
        rst_n = 1'b1;
        cyc("after", 1'b1, 1'b1, 6'h0F);
        for (int i = 0; i < 8; i++) cyc("after", 1'b1, 1'b0, '0);
        chk("after.sipo_end", 32'(sipo), 32'h0F);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc("rand", $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, SHLEN'($urandom));
        for (int i = 0; i < 20; i++) cyc("drain", 1'b1, 1'b0, '0);
        chk("drain.idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_reg_piso_tx.md
SHIFT_REG_PISO_TX -- requirements
Module: shift_reg_piso_tx

Interface
REQ-001 Parameter SHLEN, default 6, SHALL set the word width in bits; legal range 2..32.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 EN  input  1  SHALL be the serial bit-rate tick; one bit is shifted per CLK edge with EN=1.
REQ-005 LOAD_VLD  input  1  SHALL indicate that DIN holds a valid word.
REQ-006 DIN  input  SHLEN  SHALL carry the parallel word to transmit.
REQ-007 LOAD_RDY  output  1  SHALL indicate that the block can accept a word.
REQ-008 SOUT  output  1  SHALL carry the serial data, MSB first.
REQ-009 SEN  output  1  SHALL tell the downstream SIPO receiver to sample SOUT on this CLK edge.
REQ-010 BUSY  output  1  SHALL be high while a word is being shifted.
REQ-011 DONE  output  1  SHALL pulse for one cycle after the last bit of each word.

Function
REQ-012 State machine SHALL have two states, IDLE and SHIFT, plus a shift register SHREG[SHLEN], a bit counter BITCNT (0..SHLEN-1), a holding register HOLD[SHLEN] and a flag HOLD_FULL.
REQ-013 An accept SHALL occur on any edge where LOAD_VLD=1 and LOAD_RDY=1; LOAD_RDY SHALL equal ~HOLD_FULL (combinational).
REQ-014 IDLE accept: SHREG<=DIN, BITCNT<=SHLEN-1, go to SHIFT; the first bit is on SOUT in the next cycle.
REQ-015 SOUT SHALL equal SHREG[SHLEN-1] in SHIFT and 0 in IDLE; BUSY SHALL be 1 exactly when in SHIFT.
REQ-016 SEN SHALL equal EN AND (state==SHIFT), combinational, so that a SIPO driven by SEN and SOUT captures the bit on the same edge.
REQ-017 SHIFT, EN=1, BITCNT>0: SHREG shifts left by one with 0 fill, and BITCNT decrements.
REQ-018 SHIFT, EN=0: SHREG, BITCNT and SOUT SHALL hold.
REQ-019 SHIFT, accept while not (EN=1 and BITCNT=0): HOLD<=DIN and HOLD_FULL<=1.
REQ-020 SHIFT, EN=1, BITCNT=0 (last-bit edge), priority order:
- (a) If HOLD_FULL: SHREG<=HOLD, HOLD_FULL<=0, BITCNT<=SHLEN-1, stay in SHIFT.
- (b) Else if accept: SHREG<=DIN, BITCNT<=SHLEN-1, stay in SHIFT.
- (c) Else go to IDLE.
REQ-021 Case (a) SHALL NOT also accept DIN in that cycle, because LOAD_RDY=0.
REQ-022 DONE SHALL be registered: DONE<=1 on every last-bit edge, otherwise 0; the pulse occurs in the cycle after the edge, including for back-to-back words.
REQ-023 Back-to-back words SHALL have no gap: the bit-0 SEN of word N is followed by the MSB SEN of word N+1 on the next EN tick.
REQ-024 LOAD_VLD is ignored when LOAD_RDY=0; DIN SHALL only be sampled on an accept.

Reset
REQ-025 While RST_N=0, the block SHALL force state=IDLE, SHREG=0, BITCNT=0, HOLD=0, HOLD_FULL=0 and DONE=0, which gives SOUT=0, SEN=0, BUSY=0 and LOAD_RDY=1.
REQ-026 Reset asserted mid-word SHALL abandon the word and any held word immediately, with no DONE pulse.
REQ-027 The first accept after RST_N rises SHALL behave as in REQ-014.

Verification (SHLEN=6, with a SIPO of SHLEN=6 connected as EN=SEN, IN=SOUT)
REQ-028 Reset: RST_N=0 with random inputs -> SOUT=0, SEN=0, BUSY=0, DONE=0, LOAD_RDY=1.
REQ-029 Single word: accept 6'b101101 with EN=1 constantly -> SOUT = 1,0,1,1,0,1 over 6 cycles; DONE high in cycle 7; BUSY low in cycle 7; SIPO OUT=6'b101101.
REQ-030 Slow tick: EN=1 every 4th cycle, word 6'h2A -> each bit held 4 cycles; SEN pulses only coincide with EN; 6 SEN pulses total; SIPO OUT=6'h2A.
REQ-031 Back-to-back: accept 6'h2A, then 6'h15 two cycles later -> LOAD_RDY low from the second accept until the 6th bit of 6'h2A; 12 contiguous SEN bits; two DONE pulses; SIPO OUT=6'h15 at the end.
REQ-032 Same-edge load: HOLD empty and accept 6'h3F on the last-bit edge of 6'h01 -> 6'h3F MSB on SOUT in the next cycle; one DONE pulse for 6'h01.
REQ-033 Reset mid-word: RST_N=0 after 3 bits of 6'h2A with 6'h15 held -> all outputs at reset values at once, no DONE; a following accept of 6'h0F transmits cleanly.
